// File: rtl/french_pkg.sv
// Shared types and constants for the "french" sprite position controller.
package french_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE    = 2'd1,
        HIT     = 2'd2,
        RESPAWN = 2'd3
    } move_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 11;

    // One horizontal step with wrap-around inside 0..w-1.
    // The caller guarantees x < w and step < w.
    function automatic logic [COORD_W-1:0] wrap_step(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] step,
        input logic [COORD_W-1:0] w,
        input logic               right
    );
        logic [COORD_W-1:0] nx;
        if (right) begin
            nx = x + step;
            if (nx >= w) begin
                nx = nx - w;
            end else begin
                nx = nx;
            end
        end else begin
            if (x < step) begin
                nx = x + w - step;
            end else begin
                nx = x - step;
            end
        end
        return nx;
    endfunction

endpackage

// File: rtl/french_move_frame_divider.sv
// Divides a tick stream by N: tick_out fires together with every Nth tick_in.
// The pulse is combinational on tick_in so the consumer can act on the same
// clock edge as the frame pulse itself.
module frame_divider #(
    parameter int N = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic tick_in,
    output logic tick_out
);

    localparam int          CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_r;

    assign tick_out = tick_in & (cnt_r == LAST);

    // Tick counter: wraps to zero on the Nth tick, cleared on demand.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (tick_in) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/french_move.sv
// Position controller for the "french" sprite: steps X once every
// FRAMES_PER_STEP frames with screen wrap, and on a collision freezes,
// blinks for HIT_FRAMES frames and respawns at INIT_X.
module french_move #(
    parameter int INIT_X          = 0,
    parameter int INIT_Y          = 200,
    parameter int SPEED_X         = 2,
    parameter int FRAMES_PER_STEP = 2,
    parameter int DIR_RIGHT       = 1,
    parameter int SCREEN_W        = french_pkg::SCREEN_W,
    parameter int HIT_FRAMES      = 60,
    parameter int BLINK_FRAMES    = 8
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           startOfFrame,
    input  logic                           enable,
    input  logic                           collision,
    input  logic [1:0]                     speed_sel,
    output logic [french_pkg::COORD_W-1:0] ObjectStartX,
    output logic [french_pkg::COORD_W-1:0] ObjectStartY,
    output logic                           visible,
    output logic [1:0]                     state_o
);

    import french_pkg::*;

    localparam logic [COORD_W-1:0] INIT_X_C   = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] INIT_Y_C   = COORD_W'(INIT_Y);
    localparam logic [COORD_W-1:0] SPEED_X_C  = COORD_W'(SPEED_X);
    localparam logic [COORD_W-1:0] SCREEN_W_C = COORD_W'(SCREEN_W);
    localparam logic               RIGHT_C    = (DIR_RIGHT != 0);

    // The hit counter must reach HIT_FRAMES-1 and also carry the blink bit.
    localparam int BLINK_BIT = $clog2(BLINK_FRAMES);
    localparam int HIT_W     = ($clog2(HIT_FRAMES) > BLINK_BIT) ? $clog2(HIT_FRAMES) : BLINK_BIT + 1;
    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_FRAMES - 1);

    // The largest step (SPEED_X << 3) must stay below the screen width so a
    // single wrap correction is always enough.
    if (SPEED_X * 8 >= SCREEN_W) begin : g_speed_check
        $error("french_move: SPEED_X*8 must be smaller than SCREEN_W");
    end
    if (FRAMES_PER_STEP < 1) begin : g_fps_check
        $error("french_move: FRAMES_PER_STEP must be at least 1");
    end

    move_state_t        state_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic               visible_r;
    logic [HIT_W-1:0]   hit_cnt_r;

    logic [COORD_W-1:0] step_s;
    logic [HIT_W-1:0]   hit_nxt_s;
    logic               div_clear_s;
    logic               div_tick_s;
    logic               step_tick_s;

    // speed_sel is read live, so the value present on the step cycle wins.
    assign step_s    = SPEED_X_C << speed_sel;
    assign hit_nxt_s = hit_cnt_r + HIT_W'(1);

    // Frames only count while actually moving; a collision or a disable in the
    // same cycle takes priority and suppresses the step.
    assign div_tick_s  = startOfFrame & (state_r == MOVE) & enable & ~collision;
    assign div_clear_s = ((state_r == IDLE) & enable) | (state_r == RESPAWN);

    frame_divider #(
        .N (FRAMES_PER_STEP)
    ) u_step_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (div_clear_s),
        .tick_in  (div_tick_s),
        .tick_out (step_tick_s)
    );

    // Movement / hit / respawn state machine with registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            x_r       <= INIT_X_C;
            y_r       <= INIT_Y_C;
            visible_r <= 1'b1;
            hit_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    visible_r <= 1'b1;
                    if (enable) begin
                        state_r <= MOVE;
                    end
                end
                MOVE: begin
                    if (collision) begin
                        state_r   <= HIT;
                        hit_cnt_r <= '0;
                        visible_r <= 1'b1;
                    end else if (!enable) begin
                        state_r <= IDLE;
                    end else if (step_tick_s) begin
                        x_r <= wrap_step(x_r, step_s, SCREEN_W_C, RIGHT_C);
                    end
                end
                HIT: begin
                    if (startOfFrame) begin
                        if (hit_cnt_r == HIT_LAST) begin
                            state_r   <= RESPAWN;
                            hit_cnt_r <= '0;
                        end else begin
                            hit_cnt_r <= hit_nxt_s;
                            visible_r <= ~hit_nxt_s[BLINK_BIT];
                        end
                    end
                end
                RESPAWN: begin
                    x_r       <= INIT_X_C;
                    visible_r <= 1'b1;
                    state_r   <= enable ? MOVE : IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ObjectStartX = x_r;
    assign ObjectStartY = y_r;
    assign visible      = visible_r;
    assign state_o      = state_r;

endmodule

// File: tb/tb_french_move.sv
// Directed scoreboard bench for french_move: default instance plus two
// fast-stepping instances for right and left screen wrap.
module tb_french_move;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        startOfFrame;
    logic        enable;
    logic        collision;
    logic [1:0]  speed_sel;
    logic        coll_off = 1'b0;
    logic [1:0]  sel_step8 = 2'd2;

    logic [10:0] x0, y0, x1, y1, x2, y2;
    logic        v0, v1, v2;
    logic [1:0]  s0, s1, s2;

    always #5 CLK = ~CLK;

    french_move dut (
        .CLK(CLK), .RESET(RESET), .startOfFrame(startOfFrame), .enable(enable),
        .collision(collision), .speed_sel(speed_sel),
        .ObjectStartX(x0), .ObjectStartY(y0), .visible(v0), .state_o(s0)
    );

    french_move #(.INIT_X(636), .FRAMES_PER_STEP(1)) dut_wr (
        .CLK(CLK), .RESET(RESET), .startOfFrame(startOfFrame), .enable(enable),
        .collision(coll_off), .speed_sel(sel_step8),
        .ObjectStartX(x1), .ObjectStartY(y1), .visible(v1), .state_o(s1)
    );

    french_move #(.INIT_X(3), .FRAMES_PER_STEP(1), .DIR_RIGHT(0)) dut_wl (
        .CLK(CLK), .RESET(RESET), .startOfFrame(startOfFrame), .enable(enable),
        .collision(coll_off), .speed_sel(sel_step8),
        .ObjectStartX(x2), .ObjectStartY(y2), .visible(v2), .state_o(s2)
    );

    typedef struct {
        int x;
        int vis;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model of the default instance's horizontal motion.
    int   m_x;
    int   m_cnt;

    task automatic chk(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_exp(input int x, input int vis, input int st);
        exp_t e;
        e.x   = x;
        e.vis = vis;
        e.st  = st;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_q"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_x"},   int'(x0), e.x);
            chk({tag, "_y"},   int'(y0), 200);
            chk({tag, "_vis"}, int'(v0), e.vis);
            chk({tag, "_st"},  int'(s0), e.st);
        end
    endtask

    // Called at a negedge; applies one start-of-frame pulse, returns at next negedge.
    task automatic frame(input logic coll);
        startOfFrame = 1'b1;
        collision    = coll;
        @(negedge CLK);
        startOfFrame = 1'b0;
        collision    = 1'b0;
    endtask

    // One clock with the current inputs and no frame pulse.
    task automatic idle_cycle();
        @(negedge CLK);
    endtask

    // Model one frame in MOVE for FRAMES_PER_STEP = 2.
    task automatic model_frame();
        int step;
        step = 2 << speed_sel;
        if (m_cnt == 1) begin
            m_cnt = 0;
            m_x   = (m_x + step) % 640;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    int t_base[10] = '{0, 0, 2, 2, 4, 4, 6, 6, 8, 8};
    int t_wr[3]    = '{636, 4, 12};
    int t_wl[3]    = '{3, 635, 627};

    initial begin
        RESET        = 1'b1;
        startOfFrame = 1'b0;
        enable       = 1'b0;
        collision    = 1'b0;
        speed_sel    = 2'd0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        push_exp(0, 1, 0);
        check_out("reset");
        chk("reset_wr_x", int'(x1), 636);
        chk("reset_wl_x", int'(x2), 3);

        // Enable arrives with the first frame pulse; that pulse is spent in IDLE.
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_exp(t_base[i], 1, 1);
            frame(1'b0);
            check_out("basic");
            if (i < 3) begin
                chk("wrap_right_x", int'(x1), t_wr[i]);
                chk("wrap_left_x",  int'(x2), t_wl[i]);
            end
        end
        m_x   = 8;
        m_cnt = 1;

        // Step 8 until X = 40, ending just before a step-eligible frame.
        speed_sel = 2'd2;
        for (int i = 0; i < 8; i++) begin
            model_frame();
            push_exp(m_x, 1, 1);
            frame(1'b0);
            check_out("run_to_40");
        end

        // Collision on a step-eligible frame: no step, enter HIT.
        push_exp(40, 1, 2);
        frame(1'b1);
        check_out("collide");

        // Blink phase; a collision and a dropped enable mid-HIT are ignored.
        for (int k = 1; k < 60; k++) begin
            push_exp(40, ((k / 8) % 2 == 0) ? 1 : 0, 2);
            if (k == 20) begin
                enable = 1'b0;
                frame(1'b1);
                enable = 1'b1;
            end else begin
                frame(1'b0);
            end
            check_out("hit_blink");
        end
        frame(1'b0);
        chk("respawn_state", int'(s0), 3);
        push_exp(0, 1, 1);
        idle_cycle();
        check_out("after_respawn");
        m_x   = 0;
        m_cnt = 0;

        // Step 4 up to X = 20.
        speed_sel = 2'd1;
        for (int i = 0; i < 10; i++) begin
            model_frame();
            push_exp(m_x, 1, 1);
            frame(1'b0);
            check_out("run_to_20");
        end

        // Disable: IDLE, position held, collisions ignored.
        enable = 1'b0;
        push_exp(20, 1, 0);
        idle_cycle();
        check_out("disable");
        for (int i = 0; i < 5; i++) begin
            push_exp(20, 1, 0);
            frame(i == 2);
            check_out("idle_hold");
        end

        // Re-enable: motion resumes from 20 with a cleared frame counter.
        enable = 1'b1;
        push_exp(20, 1, 1);
        idle_cycle();
        check_out("reenable");
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            model_frame();
            push_exp(m_x, 1, 1);
            frame(1'b0);
            check_out("resume");
        end

        // Collision without a frame pulse, then reset in the middle of HIT.
        collision = 1'b1;
        push_exp(m_x, 1, 2);
        idle_cycle();
        collision = 1'b0;
        check_out("collide2");
        for (int k = 1; k <= 30; k++) begin
            push_exp(m_x, ((k / 8) % 2 == 0) ? 1 : 0, 2);
            frame(1'b0);
            check_out("hit2");
        end
        RESET = 1'b1;
        push_exp(0, 1, 0);
        idle_cycle();
        RESET = 1'b0;
        check_out("reset_mid_hit");
        chk("reset_mid_hit_wr_x", int'(x1), 636);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
